// File: rtl/mem_preload_if.sv
// Handshake/bus bundle for the program-image preloader.
// The slave view belongs to the loader; the master view belongs to whatever
// supplies the image, issues start and models the memory read port.
interface mem_preload_if #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int SUM_WIDTH  = REG_WIDTH + 8
);
    // control
    logic                  start;
    logic                  verify_en;
    // image stream
    logic                  src_valid;
    logic [REG_WIDTH-1:0]  src_data;
    logic                  src_ready;
    // memory port
    logic                  mem_we;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [REG_WIDTH-1:0]  mem_wdata;
    logic [REG_WIDTH-1:0]  mem_rdata;
    // status
    logic                  cpu_hold;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [SUM_WIDTH-1:0]  load_sum;
    logic [SUM_WIDTH-1:0]  read_sum;

    modport master (
        output start, verify_en, src_valid, src_data, mem_rdata,
        input  src_ready, mem_we, mem_re, mem_addr, mem_wdata,
               cpu_hold, busy, done, err, load_sum, read_sum
    );

    modport slave (
        input  start, verify_en, src_valid, src_data, mem_rdata,
        output src_ready, mem_we, mem_re, mem_addr, mem_wdata,
               cpu_hold, busy, done, err, load_sum, read_sum
    );
endinterface

// File: rtl/mem_preload.sv
// Program-image preloader: streams words into memory addresses 0..MEM_DEPTH-1
// while holding the CPU in reset, then optionally reads the image back and
// compares checksums before releasing the CPU.
module mem_preload #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_DEPTH  = 65536,
    parameter int SUM_WIDTH  = REG_WIDTH + 8
) (
    input logic         clk,
    input logic         reset,
    mem_preload_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        VERIFY,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [REG_WIDTH-1:0]  wdata_q;
    logic [SUM_WIDTH-1:0]  load_sum_q;
    logic [SUM_WIDTH-1:0]  read_sum_q;
    logic                  verify_q;
    logic                  rd_pend_q;
    logic                  src_ready_q;
    logic                  mem_re_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic                  cpu_hold_q;

    logic                  wr_fire;
    logic                  cnt_last;
    logic [SUM_WIDTH-1:0]  load_sum_d;
    logic [SUM_WIDTH-1:0]  read_sum_d;

    // Handshake, terminal count and next-sum arithmetic shared by the FSM.
    // src_ready_q is high exactly while in LOAD, so it doubles as the state qualifier.
    always_comb begin
        wr_fire    = src_ready_q & bus.src_valid;
        cnt_last   = (cnt_q == LAST_ADDR);
        load_sum_d = load_sum_q + SUM_WIDTH'(bus.src_data);
        read_sum_d = read_sum_q;
        if (rd_pend_q) begin
            read_sum_d = read_sum_q + SUM_WIDTH'(bus.mem_rdata);
        end
    end

    // Controller: state, address counter, checksums and all registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wdata_q     <= '0;
            load_sum_q  <= '0;
            read_sum_q  <= '0;
            verify_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
            src_ready_q <= 1'b0;
            mem_re_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_hold_q  <= 1'b1;
        end else begin
            // read data returns one cycle after the strobe
            rd_pend_q <= mem_re_q;
            if (wr_fire) begin
                wdata_q <= bus.src_data;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q     <= LOAD;
                        cnt_q       <= '0;
                        load_sum_q  <= '0;
                        read_sum_q  <= '0;
                        verify_q    <= bus.verify_en;
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                        src_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                        cpu_hold_q  <= 1'b1;
                    end
                end

                LOAD: begin
                    if (wr_fire) begin
                        load_sum_q <= load_sum_d;
                        if (cnt_last) begin
                            cnt_q       <= '0;
                            src_ready_q <= 1'b0;
                            if (verify_q) begin
                                state_q  <= VERIFY;
                                mem_re_q <= 1'b1;
                            end else begin
                                state_q    <= DONE;
                                busy_q     <= 1'b0;
                                done_q     <= 1'b1;
                                cpu_hold_q <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end

                VERIFY: begin
                    read_sum_q <= read_sum_d;
                    if (cnt_last) begin
                        cnt_q    <= '0;
                        mem_re_q <= 1'b0;
                        state_q  <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                DRAIN: begin
                    // last read word arrives now; compare against the completed sum
                    read_sum_q <= read_sum_d;
                    err_q      <= (load_sum_q != read_sum_d);
                    state_q    <= DONE;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    cpu_hold_q <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output wiring; the write path is combinational so it lands in the handshake cycle.
    always_comb begin
        bus.src_ready = src_ready_q;
        bus.mem_we    = wr_fire;
        bus.mem_re    = mem_re_q;
        bus.mem_addr  = cnt_q;
        bus.mem_wdata = wr_fire ? bus.src_data : wdata_q;
        bus.cpu_hold  = cpu_hold_q;
        bus.busy      = busy_q;
        bus.done      = done_q;
        bus.err       = err_q;
        bus.load_sum  = load_sum_q;
        bus.read_sum  = read_sum_q;
    end

endmodule
